// File: rtl/rvvi_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rvvi_flow_ctrl: windowed, gap-paced transmit gating for the RVVI trace   |
// | link, driven by decoded host acknowledgements, with link timeout.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rvvi_flow_ctrl #(
    parameter int FRAME_COUNT_WIDTH = 64,
    parameter int MAX_OUTSTANDING   = 8,
    parameter int INIT_DELAY        = 0,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         AckValid,
    input  logic [FRAME_COUNT_WIDTH-1:0] AckFrameCount,
    input  logic [31:0]                  AckDelay,
    input  logic                         TxReq,
    output logic                         TxGrant,
    input  logic                         TxDone,
    output logic [FRAME_COUNT_WIDTH-1:0] SentCount,
    output logic [FRAME_COUNT_WIDTH-1:0] AckedCount,
    output logic [FRAME_COUNT_WIDTH-1:0] Outstanding,
    output logic                         AckError,
    output logic                         Timeout
);

    localparam int                         c_IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0]        c_TIMEOUT    = c_IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [c_IDLE_W-1:0]        c_IDLE_ONE   = c_IDLE_W'(1);
    localparam logic [FRAME_COUNT_WIDTH-1:0] c_MAX_OUT  = FRAME_COUNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [FRAME_COUNT_WIDTH-1:0] c_CNT_ONE  = FRAME_COUNT_WIDTH'(1);
    localparam logic [FRAME_COUNT_WIDTH-1:0] c_CNT_ZERO = '0;
    localparam logic [31:0]                c_INIT_DELAY = 32'(INIT_DELAY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SENDING = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;
    logic [FRAME_COUNT_WIDTH-1:0]   r_sent;
    logic [FRAME_COUNT_WIDTH-1:0]   r_acked;
    logic [31:0]                    r_delay;
    logic [31:0]                    r_gap;
    logic [c_IDLE_W-1:0]            r_idle_cnt;
    logic                           r_ack_error;
    logic                           r_timeout;

    logic [FRAME_COUNT_WIDTH-1:0]   w_outstanding;
    logic [FRAME_COUNT_WIDTH-1:0]   w_ack_dist;
    logic                           w_accept;
    logic                           w_idle_clr;
    logic                           w_frame_done;
    logic                           w_grant;

    // Wrap-safe window check: the acked count may only move forward, and
    // never past the frames already completed before this edge.
    assign w_outstanding = r_sent - r_acked;
    assign w_ack_dist    = AckFrameCount - r_acked;
    assign w_accept      = AckValid && (w_ack_dist <= w_outstanding);
    assign w_idle_clr    = w_accept || (w_outstanding == c_CNT_ZERO);
    assign w_frame_done  = (r_state == SENDING) && TxDone;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant = TxReq && (w_outstanding < c_MAX_OUT) && !reset;
                if (w_grant) begin
                    w_next_state = SENDING;
                end
            end
            SENDING: begin
                if (TxDone) begin
                    w_next_state = (r_delay == 32'd0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (r_gap == 32'd1) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sent      <= '0;
            r_acked     <= '0;
            r_delay     <= c_INIT_DELAY;
            r_gap       <= '0;
            r_idle_cnt  <= '0;
            r_ack_error <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_sent <= r_sent + c_CNT_ONE;
            end
            if (w_accept) begin
                r_acked <= AckFrameCount;
                r_delay <= AckDelay;
            end
            // The gap loads the delay in force before this edge, so a
            // concurrent acknowledgement only affects later frames.
            if (w_frame_done) begin
                r_gap <= r_delay;
            end else if (r_state == GAP) begin
                r_gap <= r_gap - 32'd1;
            end
            r_ack_error <= AckValid && !w_accept;
            if (w_idle_clr) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_TIMEOUT) begin
                r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
            end
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (!w_idle_clr && (r_idle_cnt >= c_TIMEOUT - c_IDLE_ONE)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign TxGrant     = w_grant;
    assign SentCount   = r_sent;
    assign AckedCount  = r_acked;
    assign Outstanding = w_outstanding;
    assign AckError    = r_ack_error;
    assign Timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rvvi_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rvvi_flow_ctrl: directed bench for rvvi_flow_ctrl (8-bit counters,    |
// | window 8, no initial gap, 100-cycle timeout).                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rvvi_flow_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ack_valid = 1'b0;
    logic [7:0]  ack_count = '0;
    logic [31:0] ack_delay = '0;
    logic        tx_req = 1'b0;
    logic        tx_grant;
    logic        tx_done = 1'b0;
    logic [7:0]  sent;
    logic [7:0]  acked;
    logic [7:0]  outst;
    logic        ack_err;
    logic        tmo;

    int n_cmp = 0;
    int n_err = 0;

    rvvi_flow_ctrl #(
        .FRAME_COUNT_WIDTH (8),
        .MAX_OUTSTANDING   (8),
        .INIT_DELAY        (0),
        .TIMEOUT_CYCLES    (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .AckValid      (ack_valid),
        .AckFrameCount (ack_count),
        .AckDelay      (ack_delay),
        .TxReq         (tx_req),
        .TxGrant       (tx_grant),
        .TxDone        (tx_done),
        .SentCount     (sent),
        .AckedCount    (acked),
        .Outstanding   (outst),
        .AckError      (ack_err),
        .Timeout       (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        tx_req    = 1'b0;
        tx_done   = 1'b0;
        ack_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Grant in IDLE, TxDone lat cycles after the grant; returns in the
    // first cycle after the TxDone edge.
    task automatic frame(input int lat);
        tx_req = 1'b1;
        #1;
        chk("grant_idle", 64'(tx_grant), 64'd1);
        tick();
        tx_req = 1'b1;
        #1;
        chk("grant_sending", 64'(tx_grant), 64'd0);
        tx_req = 1'b0;
        repeat (lat - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic ack(input logic [7:0] cnt, input logic [31:0] dly);
        ack_valid = 1'b1;
        ack_count = cnt;
        ack_delay = dly;
        tick();
        ack_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: grant suppressed while reset is high
        tx_req = 1'b1;
        #2;
        chk("grant_in_reset", 64'(tx_grant), 64'd0);
        reset_dut();
        chk("rst_sent", 64'(sent), 64'd0);
        chk("rst_acked", 64'(acked), 64'd0);
        chk("rst_outst", 64'(outst), 64'd0);
        chk("rst_err", 64'(ack_err), 64'd0);
        chk("rst_tmo", 64'(tmo), 64'd0);

        // Basic pacing, zero gap
        for (int i = 1; i <= 3; i++) begin
            frame(4);
            chk("pace_sent", 64'(sent), 64'(i));
        end
        tx_req  = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        #1;
        chk("stray_done_ignored", 64'(sent), 64'd3);

        // Gap enforcement
        ack(8'd3, 32'd5);
        chk("gap_ack_acked", 64'(acked), 64'd3);
        chk("gap_ack_outst", 64'(outst), 64'd0);
        chk("gap_ack_err", 64'(ack_err), 64'd0);
        frame(2);
        chk("gap_sent", 64'(sent), 64'd4);
        for (int i = 0; i < 5; i++) begin
            tx_req = 1'b1;
            #1;
            chk("gap_no_grant", 64'(tx_grant), 64'd0);
            tick();
        end
        #1;
        chk("gap_end_grant", 64'(tx_grant), 64'd1);

        // Reset in the middle of a gap
        frame(2);
        tick();
        tick();
        reset  = 1'b1;
        tx_req = 1'b1;
        #1;
        chk("midgap_rst_grant", 64'(tx_grant), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("midgap_rst_sent", 64'(sent), 64'd0);
        chk("midgap_rst_acked", 64'(acked), 64'd0);
        chk("midgap_rst_outst", 64'(outst), 64'd0);
        tx_req  = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        #1;
        chk("aborted_done_ignored", 64'(sent), 64'd0);
        frame(2);
        tx_req = 1'b1;
        #1;
        chk("init_delay_restored", 64'(tx_grant), 64'd1);
        chk("post_rst_sent", 64'(sent), 64'd1);

        // Window full
        reset_dut();
        for (int i = 0; i < 8; i++) frame(2);
        chk("win_outst", 64'(outst), 64'd8);
        for (int i = 0; i < 3; i++) begin
            tx_req = 1'b1;
            #1;
            chk("win_full_no_grant", 64'(tx_grant), 64'd0);
            tick();
        end
        ack_valid = 1'b1;
        ack_count = 8'd3;
        ack_delay = 32'd0;
        #1;
        chk("win_ack_cycle_no_grant", 64'(tx_grant), 64'd0);
        tick();
        ack_valid = 1'b0;
        #1;
        chk("win_after_ack_outst", 64'(outst), 64'd5);
        chk("win_after_ack_grant", 64'(tx_grant), 64'd1);

        // Bad and duplicate acknowledgements: sent 10, acked 4
        frame(2);
        frame(2);
        ack(8'd4, 32'd0);
        chk("bad_setup_sent", 64'(sent), 64'd10);
        chk("bad_setup_acked", 64'(acked), 64'd4);
        ack(8'd12, 32'd0);
        chk("bad_err", 64'(ack_err), 64'd1);
        chk("bad_acked_kept", 64'(acked), 64'd4);
        tick();
        chk("bad_err_pulse", 64'(ack_err), 64'd0);
        ack(8'd4, 32'd0);
        chk("dup_err", 64'(ack_err), 64'd0);
        chk("dup_acked", 64'(acked), 64'd4);
        ack(8'd10, 32'd0);
        chk("edge_ack_acked", 64'(acked), 64'd10);
        chk("edge_ack_outst", 64'(outst), 64'd0);
        chk("edge_ack_err", 64'(ack_err), 64'd0);

        // Ack naming the frame that completes in the same edge
        tx_req = 1'b1;
        #1;
        chk("simul_grant", 64'(tx_grant), 64'd1);
        tick();
        tx_req    = 1'b0;
        tx_done   = 1'b1;
        ack_valid = 1'b1;
        ack_count = 8'd11;
        tick();
        tx_done   = 1'b0;
        ack_valid = 1'b0;
        #1;
        chk("simul_sent", 64'(sent), 64'd11);
        chk("simul_acked", 64'(acked), 64'd10);
        chk("simul_err", 64'(ack_err), 64'd1);

        // Wrap-around of 8-bit counters
        reset_dut();
        for (int i = 1; i <= 258; i++) begin
            frame(1);
            if (i <= 250) ack(i[7:0], 32'd0);
        end
        chk("wrap_sent", 64'(sent), 64'd2);
        chk("wrap_acked", 64'(acked), 64'd250);
        chk("wrap_outst", 64'(outst), 64'd8);
        ack(8'd3, 32'd0);
        chk("wrap_reject_err", 64'(ack_err), 64'd1);
        chk("wrap_reject_acked", 64'(acked), 64'd250);
        ack(8'd1, 32'd0);
        chk("wrap_accept_acked", 64'(acked), 64'd1);
        chk("wrap_accept_outst", 64'(outst), 64'd1);
        chk("wrap_accept_err", 64'(ack_err), 64'd0);

        // Timeout: one frame outstanding, last accepted ack just now
        repeat (99) tick();
        chk("tmo_before", 64'(tmo), 64'd0);
        tick();
        chk("tmo_rise", 64'(tmo), 64'd1);
        repeat (20) tick();
        chk("tmo_sticky", 64'(tmo), 64'd1);
        ack(8'd1, 32'd0);
        chk("tmo_cleared", 64'(tmo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
